// File: rtl/step_ctl_if.sv
// Step link from the front-panel step generator to ss_core:
// a fixed-width ss strobe qualified by an active-low si_n level.
interface step_ctl_if;
    logic ss;
    logic si_n;

    modport master (output ss, output si_n);
    modport slave  (input ss, input si_n);
endinterface

// File: rtl/step_ctl.sv
// Front-panel STEP generator: debounces the raw pushbutton, emits fixed-width
// ss strobes with a matching si_n level, optional auto-repeat and a step count.
module step_ctl #(
    parameter int DB_CYCLES     = 10000,
    parameter int SS_WIDTH      = 3,
    parameter int REPEAT_DELAY  = 500000,
    parameter int REPEAT_PERIOD = 100000,
    parameter int CW            = 20
) (
    input  logic        phi2,
    input  logic        rst_n,
    input  logic        btn_n,
    input  logic        inst_n,
    input  logic        auto_en,
    step_ctl_if.master  step,
    output logic        busy,
    output logic [15:0] step_cnt
);

    typedef enum logic [2:0] {IDLE, DB_PRESS, PULSE, HOLD, DB_REL} state_t;

    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] DB_T = CW'(DB_CYCLES);
    localparam logic [CW-1:0] SS_T = CW'(SS_WIDTH);
    localparam logic [CW-1:0] RD_T = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] RP_T = CW'(REPEAT_PERIOD);

    state_t        state;
    logic [CW-1:0] timer;
    logic          repeating;
    logic          sync1;
    logic          sync2;
    logic          btn_s;
    logic          ss_q;
    logic          si_n_q;

    assign step.ss   = ss_q;
    assign step.si_n = si_n_q;
    assign btn_s     = ~sync2;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + ONE;
    endfunction

    // btn_n is asynchronous to phi2; resting level is released (1)
    always_ff @(posedge phi2 or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge phi2 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            repeating <= 1'b0;
            ss_q      <= 1'b0;
            si_n_q    <= 1'b1;
            busy      <= 1'b0;
            step_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (btn_s) begin
                        state <= DB_PRESS;
                        timer <= ONE;
                        busy  <= 1'b1;
                    end else begin
                        timer <= '0;
                    end
                end
                DB_PRESS: begin
                    if (!btn_s) begin
                        state <= IDLE;
                        timer <= '0;
                        busy  <= 1'b0;
                    end else if (timer >= DB_T) begin
                        state     <= PULSE;
                        timer     <= ONE;
                        ss_q      <= 1'b1;
                        si_n_q    <= inst_n;
                        step_cnt  <= step_cnt + 16'd1;
                        repeating <= 1'b0;
                    end else begin
                        timer <= sat_inc(timer);
                    end
                end
                // timer keeps running from strobe start so HOLD can time repeats
                PULSE: begin
                    timer <= sat_inc(timer);
                    if (timer >= SS_T) begin
                        ss_q   <= 1'b0;
                        si_n_q <= 1'b1;
                        state  <= HOLD;
                    end
                end
                HOLD: begin
                    if (!btn_s) begin
                        state <= DB_REL;
                        timer <= ONE;
                    end else if (auto_en && (timer >= (repeating ? RP_T : RD_T))) begin
                        state     <= PULSE;
                        timer     <= ONE;
                        ss_q      <= 1'b1;
                        si_n_q    <= inst_n;
                        step_cnt  <= step_cnt + 16'd1;
                        repeating <= 1'b1;
                    end else begin
                        timer <= sat_inc(timer);
                    end
                end
                DB_REL: begin
                    if (btn_s) begin
                        state <= HOLD;
                        timer <= '0;
                    end else if (timer >= DB_T) begin
                        state <= IDLE;
                        timer <= '0;
                        busy  <= 1'b0;
                    end else begin
                        timer <= sat_inc(timer);
                    end
                end
                default: begin
                    state  <= IDLE;
                    timer  <= '0;
                    ss_q   <= 1'b0;
                    si_n_q <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/step_ctl.md
Name: step_ctl

Overview:
- Front-panel step-command generator; the transmitting end of the ss/si_n step interface consumed by ss_core.
- Takes a raw bouncing STEP pushbutton and the CYCLE/INSTRUCTION mode switch. Produces clean, fixed-width ss strobes with a matching si_n level.
- Supports optional auto-repeat while the button is held, and keeps a step counter for the debug display.
- Clocked by the 6502 phi2 in the XC9500 debug CPLD.

Parameters:
- DB_CYCLES, 10000: consecutive stable synchronised phi2 cycles required to accept a press or release (10 ms at 1 MHz).
- SS_WIDTH, 3: phi2 cycles that ss is held high per step.
- REPEAT_DELAY, 500000: hold time from the start of the first strobe to the first auto-repeat strobe.
- REPEAT_PERIOD, 100000: strobe-start to strobe-start spacing during auto-repeat.
- CW, 20: width of the shared timer. Must hold the largest of the three timing values.

Ports:
- phi2, input, 1: CPU phase-2 clock. All logic is on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- btn_n, input, 1: raw STEP pushbutton, active low, asynchronous to phi2, bouncing.
- inst_n, input, 1: mode switch. 0 = step instruction, 1 = step cycle. Static.
- auto_en, input, 1: 1 enables auto-repeat while the button is held.
- ss, output, 1: step strobe to ss_core.
- si_n, output, 1: step-instruction qualifier to ss_core, active low.
- busy, output, 1: high in any state other than IDLE.
- step_cnt, output, 16: number of strobes issued. Wraps at 16 bits.

Behaviour:
- Reset values (async on rst_n low): ss=0, si_n=1, busy=0, step_cnt=0, state=IDLE, timer=0, synchroniser flops=1.
- Reset mid-strobe drops ss immediately. On rst_n release the block returns to IDLE and needs a fresh debounced press.
- btn_n passes through a 2-flop synchroniser; btn_s is the synchronised active-high press.
- inst_n is sampled only at strobe start.
- States:
  - IDLE: timer=0. btn_s=1 -> DB_PRESS with timer=1.
  - DB_PRESS: btn_s=1 -> timer+1. btn_s=0 -> IDLE. When timer reaches DB_CYCLES (with btn_s=1) -> PULSE.
  - PULSE: entry edge sets ss=1, si_n=inst_n, step_cnt+1, timer=1.
    - ss stays high for exactly SS_WIDTH edges.
    - On the edge after the last high cycle: ss=0, si_n=1, then -> HOLD.
    - si_n is only ever low while ss is high. It rises and falls on the same edges as ss.
  - HOLD: timer keeps counting from strobe start.
    - btn_s=0 -> DB_REL with timer=1.
    - auto_en=1 and timer reaches REPEAT_DELAY (first repeat) or REPEAT_PERIOD (later repeats) -> PULSE.
    - auto_en=0 -> stays in HOLD; exactly one strobe per press (lockout).
  - DB_REL: btn_s=0 -> timer+1. btn_s=1 -> HOLD, timer restarted from 0, no strobe.
    - When timer reaches DB_CYCLES -> IDLE.
    - No new press is accepted until release is debounced.
- Latency: a clean press with btn_n low before edge 0 -> btn_s=1 after edge 1 -> ss rises on edge DB_CYCLES+2.
- Button released during PULSE: the strobe still completes full width, then HOLD -> DB_REL.
- A bounce shorter than DB_CYCLES in DB_PRESS restarts debounce from IDLE. No strobe.
- auto_en dropped during HOLD: no further repeats; the in-flight timer is ignored.
- inst_n changed while ss is high: no effect on si_n until the next strobe.
- Timer saturates at 2^CW-1 and never wraps.
- step_cnt wraps 0xFFFF -> 0x0000.

Test Plan (DB_CYCLES=4, SS_WIDTH=3, REPEAT_DELAY=20, REPEAT_PERIOD=10):
1. Reset, then a clean btn_n low held 30 cycles, inst_n=1, auto_en=0 -> ss high on edges 6-8 only, si_n=1 throughout, step_cnt=1, busy=1 until 4+2 cycles after release.
2. btn_n glitches low for 2 cycles, three times, then stays high -> ss never rises, step_cnt=0, busy returns to 0.
3. inst_n=0, clean press -> si_n=0 exactly while ss=1 (3 cycles), si_n=1 otherwise. Toggling inst_n mid-strobe does not change si_n.
4. auto_en=1, button held 60 cycles from the first ss rise -> ss rises at offsets 0, 20, 30, 40, 50 (each 3 wide), step_cnt=5. Release -> no further strobes.
5. Release bounce: after a strobe, btn_n toggles high/low every 2 cycles, then goes high -> no second strobe. IDLE is reached 4+2 cycles after the final release.
6. rst_n asserted on the second ss-high cycle -> ss=0 and si_n=1 immediately, step_cnt=0. Button still held after reset -> a new strobe occurs 6 edges later. step_cnt preset near wrap (0xFFFF) then one press -> 0x0000.
